memory_stage: RTL and testbench

Pipeline MEMORY stage sitting directly downstream of execute: registers execute's result (ALU output, store data, control), performs data-memory loads/stores over a req/ack handshake, aligns and extends sub-word data, and presents the result to writeback. Stalls the upstream pipeline while a memory access is outstanding and exposes its current contents for MX bypassing and load-use hazard detection.

---
 rtl/memory_stage_pkg.sv | 22 ++
 rtl/memory_stage_align.sv | 49 ++++
 rtl/memory_stage.sv | 132 +++++++++++++
 tb/tb_memory_stage.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/memory_stage_pkg.sv
// rtl/memory_stage_pkg.sv - shared types and constants for the memory pipeline stage
package memory_stage_pkg;

    typedef enum logic {ST_IDLE, ST_ACCESS} state_t;

    typedef enum logic [1:0] {SIZE_BYTE, SIZE_HALF, SIZE_WORD} size_t;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE0   = 4'b1000;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    function automatic logic is_misaligned(input size_t size, input logic [1:0] lo);
        case (size)
            SIZE_HALF: is_misaligned = lo[0];
            SIZE_WORD: is_misaligned = |lo;
            default:   is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/memory_stage_align.sv
// rtl/memory_stage_align.sv - big-endian store lane replication and load lane select/extend
module mem_align
    import memory_stage_pkg::*;
(
    input  size_t       size,
    input  logic [1:0]  addr_lo,
    input  logic        is_unsigned,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] load_data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // addr_lo == 0 selects the most significant byte
    always_comb begin
        case (addr_lo)
            2'd0:    lane_b = rdata[31:24];
            2'd1:    lane_b = rdata[23:16];
            2'd2:    lane_b = rdata[15:8];
            default: lane_b = rdata[7:0];
        endcase
    end

    assign lane_h = addr_lo[1] ? rdata[15:0] : rdata[31:16];

    always_comb begin
        wdata     = store_data;
        be        = BE_WORD;
        load_data = rdata;
        case (size)
            SIZE_BYTE: begin
                wdata     = {4{store_data[7:0]}};
                be        = BE_BYTE0 >> addr_lo;
                load_data = is_unsigned ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
            end
            SIZE_HALF: begin
                wdata     = {2{store_data[15:0]}};
                be        = addr_lo[1] ? BE_HALF_LO : BE_HALF_HI;
                load_data = is_unsigned ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - pipeline M stage: data-memory access, stall generation, writeback register
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              ex_valid,
    input  logic [31:0]       ex_aluOut,
    input  logic [31:0]       ex_rBOut,
    input  logic              ex_dmwe,
    input  logic              ex_rwd,
    input  logic              ex_rwe,
    input  logic [4:0]        ex_rd,
    input  logic              ex_dm_byte,
    input  logic              ex_dm_half,
    input  logic              ex_unsigned,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_wdata,
    output logic [3:0]        dm_be,
    input  logic              dm_ack,
    input  logic [31:0]       dm_rdata,
    output logic              mem_stall,
    output logic [31:0]       mx_bypass,
    output logic [4:0]        mx_rd,
    output logic              mx_rwe,
    output logic              mx_is_load,
    output logic              mem_misaligned,
    output logic              wb_valid,
    output logic [31:0]       wb_data,
    output logic [4:0]        wb_rd,
    output logic              wb_rwe
);

    state_t      state;
    logic        m_valid, m_dmwe, m_rwd, m_rwe, m_unsigned;
    logic [31:0] m_alu, m_rb;
    logic [4:0]  m_rd;
    size_t       m_size;

    size_t       ex_size;
    logic        ex_mem, ex_bad, in_access;
    logic [31:0] st_wdata, ld_data;
    logic [3:0]  st_be;

    assign ex_size   = ex_dm_byte ? SIZE_BYTE : (ex_dm_half ? SIZE_HALF : SIZE_WORD);
    assign ex_mem    = ex_valid && (ex_dmwe || ex_rwd);
    assign ex_bad    = is_misaligned(ex_size, ex_aluOut[1:0]);
    assign in_access = (state == ST_ACCESS);
    assign mem_stall = in_access && !dm_ack;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_valid    <= 1'b0;
            m_alu      <= '0;
            m_rb       <= '0;
            m_dmwe     <= 1'b0;
            m_rwd      <= 1'b0;
            m_rwe      <= 1'b0;
            m_rd       <= '0;
            m_size     <= SIZE_WORD;
            m_unsigned <= 1'b0;
        end else if (!mem_stall) begin
            m_valid    <= ex_valid;
            m_alu      <= ex_aluOut;
            m_rb       <= ex_rBOut;
            m_dmwe     <= ex_dmwe;
            m_rwd      <= ex_rwd;
            m_rwe      <= ex_rwe;
            m_rd       <= ex_rd;
            m_size     <= ex_size;
            m_unsigned <= ex_unsigned;
        end
    end

    // A misaligned op never enters ACCESS; its pulse lasts while it sits in M
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            mem_misaligned <= 1'b0;
        end else if (!mem_stall) begin
            state          <= (ex_mem && !ex_bad) ? ST_ACCESS : ST_IDLE;
            mem_misaligned <= ex_mem && ex_bad;
        end else begin
            mem_misaligned <= 1'b0;
        end
    end

    // Stalled cycles hand a bubble to writeback so an entry is seen only once
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wb_valid <= 1'b0;
            wb_rwe   <= 1'b0;
            wb_data  <= '0;
            wb_rd    <= '0;
        end else if (mem_stall) begin
            wb_valid <= 1'b0;
            wb_rwe   <= 1'b0;
        end else begin
            wb_valid <= m_valid;
            wb_rwe   <= m_valid && m_rwe && !mem_misaligned;
            wb_rd    <= m_rd;
            wb_data  <= (in_access && m_rwd) ? ld_data : m_alu;
        end
    end

    mem_align u_align (
        .size        (m_size),
        .addr_lo     (m_alu[1:0]),
        .is_unsigned (m_unsigned),
        .store_data  (m_rb),
        .rdata       (dm_rdata),
        .wdata       (st_wdata),
        .be          (st_be),
        .load_data   (ld_data)
    );

    assign dm_req     = in_access;
    assign dm_we      = in_access && m_dmwe;
    assign dm_addr    = {m_alu[ADDR_W-1:2], 2'b00};
    assign dm_wdata   = st_wdata;
    assign dm_be      = in_access ? st_be : BE_NONE;

    assign mx_bypass  = m_alu;
    assign mx_rd      = m_rd;
    assign mx_rwe     = m_valid && m_rwe;
    assign mx_is_load = m_valid && m_rwd;

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - scoreboard bench for memory_stage
module tb_memory_stage;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        ex_valid = 1'b0, ex_dmwe = 1'b0, ex_rwd = 1'b0, ex_rwe = 1'b0;
    logic        ex_dm_byte = 1'b0, ex_dm_half = 1'b0, ex_unsigned = 1'b0;
    logic [31:0] ex_aluOut = '0, ex_rBOut = '0;
    logic [4:0]  ex_rd = '0;
    logic        dm_req, dm_we, dm_ack = 1'b0;
    logic [31:0] dm_addr, dm_wdata, dm_rdata = '0;
    logic [3:0]  dm_be;
    logic        mem_stall, mx_rwe, mx_is_load, mem_misaligned;
    logic [31:0] mx_bypass, wb_data;
    logic [4:0]  mx_rd, wb_rd;
    logic        wb_valid, wb_rwe;

    int          total = 0;
    int          bad = 0;
    logic [37:0] sb[$];
    int          ack_wait = 0;
    int          wait_cnt = 0;
    logic        force_ack = 1'b0;
    int          cyc = 0, last_wb = 0, prev_wb = 0;
    int          stall_cycles = 0, req_cycles = 0;

    memory_stage #(.ADDR_W(32)) dut (
        .clock(clock), .reset_n(reset_n),
        .ex_valid(ex_valid), .ex_aluOut(ex_aluOut), .ex_rBOut(ex_rBOut),
        .ex_dmwe(ex_dmwe), .ex_rwd(ex_rwd), .ex_rwe(ex_rwe), .ex_rd(ex_rd),
        .ex_dm_byte(ex_dm_byte), .ex_dm_half(ex_dm_half), .ex_unsigned(ex_unsigned),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_be(dm_be), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .mem_stall(mem_stall), .mx_bypass(mx_bypass), .mx_rd(mx_rd),
        .mx_rwe(mx_rwe), .mx_is_load(mx_is_load), .mem_misaligned(mem_misaligned),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .wb_rwe(wb_rwe)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    // memory responder: acks after ack_wait non-ack cycles of a request
    initial forever begin
        @(negedge clock);
        if (force_ack) begin
            dm_ack = 1'b1;
        end else if (dm_req) begin
            if (wait_cnt >= ack_wait) begin
                dm_ack = 1'b1;
                wait_cnt = 0;
            end else begin
                dm_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            dm_ack = 1'b0;
            wait_cnt = 0;
        end
    end

    // writeback monitor
    initial forever begin
        @(negedge clock);
        #1;
        cyc++;
        if (mem_stall) stall_cycles++;
        if (dm_req) req_cycles++;
        if (wb_valid) begin
            prev_wb = last_wb;
            last_wb = cyc;
            if (sb.size() == 0) check("wb_extra", 1, 0);
            else check("wb_entry", {wb_rd, wb_rwe, wb_data}, sb.pop_front());
        end
    end

    // sz: 0 word, 1 half, 2 byte
    task automatic send(input logic dmwe, input logic rwd, input logic rwe, input logic [1:0] sz,
                        input logic uns, input logic [31:0] alu, input logic [31:0] rb,
                        input logic [4:0] rd, input logic [31:0] exp_data, input logic exp_rwe);
        logic stalled;
        int   budget;
        ex_valid = 1'b1; ex_dmwe = dmwe; ex_rwd = rwd; ex_rwe = rwe;
        ex_dm_half = (sz == 2'd1); ex_dm_byte = (sz == 2'd2); ex_unsigned = uns;
        ex_aluOut = alu; ex_rBOut = rb; ex_rd = rd;
        sb.push_back({rd, exp_rwe, exp_data});
        budget = 0;
        do begin
            @(negedge clock);
            #2;
            stalled = mem_stall;
            @(posedge clock);
            #1;
            budget++;
        end while (stalled && budget < 200);
        if (stalled) check("capture_timeout", 1, 0);
    endtask

    task automatic idle(input int n);
        ex_valid = 1'b0; ex_dmwe = 1'b0; ex_rwd = 1'b0; ex_rwe = 1'b0;
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        #2 reset_n = 1'b0;
        #10;
        check("rst_dm_req", dm_req, 0);
        check("rst_dm_be", dm_be, 0);
        check("rst_stall", mem_stall, 0);
        check("rst_mx", {mx_rd, mx_rwe, mx_is_load, mx_bypass}, 0);
        check("rst_wb", {wb_valid, wb_rwe, wb_rd, wb_data, mem_misaligned}, 0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        idle(1);

        // ADD
        send(0, 0, 1, 0, 0, 32'h1234_5678, 0, 5'd3, 32'h1234_5678, 1);
        check("add_no_req", dm_req, 0);
        check("add_mx", {mx_rd, mx_rwe, mx_is_load, mx_bypass}, {5'd3, 1'b1, 1'b0, 32'h1234_5678});
        idle(2);

        // SB 0xAB @0x101
        send(1, 0, 0, 2, 0, 32'h0000_0101, 32'h0000_00AB, 5'd0, 32'h0000_0101, 0);
        check("sb_req", {dm_req, dm_we}, 2'b11);
        check("sb_be", dm_be, 4'b0100);
        check("sb_wdata", dm_wdata, 32'hABAB_ABAB);
        check("sb_addr", dm_addr, 32'h0000_0100);
        idle(2);

        // SH 0x5A5A @0x102
        send(1, 0, 0, 1, 0, 32'h0000_0102, 32'h0000_5A5A, 5'd0, 32'h0000_0102, 0);
        check("sh_be", dm_be, 4'b0011);
        check("sh_wdata", dm_wdata, 32'h5A5A_5A5A);
        idle(2);

        // LB @0x103, 3 wait cycles
        ack_wait = 3;
        dm_rdata = 32'h0000_00F0;
        stall_cycles = 0;
        send(0, 1, 1, 2, 0, 32'h0000_0103, 0, 5'd4, 32'hFFFF_FFF0, 1);
        check("lb_mx_load", {mx_is_load, dm_we}, 2'b10);
        idle(7);
        check("lb_stall_cycles", stall_cycles, 3);

        // LBU @0x103, zero wait
        ack_wait = 0;
        send(0, 1, 1, 2, 1, 32'h0000_0103, 0, 5'd4, 32'h0000_00F0, 1);
        idle(2);

        // LH @0x102
        dm_rdata = 32'h1234_8001;
        send(0, 1, 1, 1, 0, 32'h0000_0102, 0, 5'd9, 32'hFFFF_8001, 1);
        idle(2);

        // LW @0x002 misaligned
        send(0, 1, 1, 0, 0, 32'h0000_0002, 0, 5'd10, 32'h0000_0002, 0);
        check("mis_pulse", mem_misaligned, 1);
        check("mis_no_req", dm_req, 0);
        idle(1);
        check("mis_pulse_end", mem_misaligned, 0);
        idle(2);

        // two back-to-back LWs, zero wait
        dm_rdata = 32'hCAFE_BABE;
        stall_cycles = 0;
        req_cycles = 0;
        send(0, 1, 1, 0, 0, 32'h0000_0200, 0, 5'd5, 32'hCAFE_BABE, 1);
        send(0, 1, 1, 0, 0, 32'h0000_0204, 0, 5'd6, 32'hCAFE_BABE, 1);
        idle(4);
        check("b2b_stall", stall_cycles, 0);
        check("b2b_req", req_cycles, 2);
        check("b2b_wb_gap", last_wb - prev_wb, 1);

        // reset during ACCESS
        ack_wait = 1000;
        send(0, 1, 1, 0, 0, 32'h0000_0300, 0, 5'd7, 32'h0, 1);
        idle(2);
        #2;
        check("rst_mid_req_before", dm_req, 1);
        reset_n = 1'b0;
        #1;
        check("rst_mid_req", dm_req, 0);
        check("rst_mid_stall", mem_stall, 0);
        sb.delete();
        force_ack = 1'b1;
        @(posedge clock);
        #1 reset_n = 1'b1;
        idle(4);
        check("rst_mid_wb", wb_valid, 0);
        force_ack = 1'b0;
        ack_wait = 0;

        // recovery after reset
        send(0, 0, 1, 0, 0, 32'h0BAD_F00D, 0, 5'd12, 32'h0BAD_F00D, 1);
        idle(3);
        check("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running want=done");
        $fatal(1);
    end

endmodule
